// File: rtl/rv32m_arbiter.sv
// rv32m_arbiter: round-robin arbiter and sequencer that shares one external
// RV32M multiply/divide unit among N_REQ execute-stage requesters. One
// operation is outstanding at a time. The unit receives a one-cycle start
// pulse with operands that stay stable until its ack. The granted requester
// receives a one-cycle ack with the result, unless it dropped its request
// while the operation was in flight.
module rv32m_arbiter #(
    parameter int  XLEN  = 32,
    parameter int  N_REQ = 2,
    localparam int GW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_REQ-1:0]      i_req_en,
    input  logic [N_REQ*XLEN-1:0] i_req_rs1,
    input  logic [N_REQ*XLEN-1:0] i_req_rs2,
    input  logic [N_REQ*3-1:0]    i_req_f3,
    output logic [N_REQ-1:0]      o_req_ack,
    output logic [XLEN-1:0]       o_req_res,
    output logic                  o_m_en,
    output logic [XLEN-1:0]       o_m_rs1,
    output logic [XLEN-1:0]       o_m_rs2,
    output logic [2:0]            o_m_f3,
    input  logic                  i_m_ack,
    input  logic [XLEN-1:0]       i_m_res,
    output logic                  o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic            aborted_q, aborted_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] res_q, res_d;

    // Unpacked per-requester views of the packed operand buses
    logic [XLEN-1:0] req_rs1 [N_REQ];
    logic [XLEN-1:0] req_rs2 [N_REQ];
    logic [2:0]      req_f3  [N_REQ];

    // Rotated search order: cand_idx[k] is the requester checked k-th,
    // i.e. (rr_ptr + k) mod N_REQ; req_rot[k] is its request bit.
    logic [GW:0]      cand_sum [N_REQ];
    logic [GW-1:0]    cand_idx [N_REQ];
    logic [N_REQ-1:0] req_rot;

    logic [GW-1:0]    pick_idx;
    logic [GW-1:0]    grant_inc;
    logic             ack_fire;

    // The ack is only delivered if the granted requester held its enable
    // for the whole ISSUE/WAIT window.
    assign ack_fire = (state_q == ST_RESP) && !aborted_q;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign req_rs1[gi]  = i_req_rs1[gi*XLEN +: XLEN];
            assign req_rs2[gi]  = i_req_rs2[gi*XLEN +: XLEN];
            assign req_f3[gi]   = i_req_f3[gi*3 +: 3];

            // The sum never exceeds 2*N_REQ-2, so a single conditional
            // subtract is enough to wrap it.
            assign cand_sum[gi] = {1'b0, rr_ptr_q} + (GW+1)'(gi);
            assign cand_idx[gi] = (cand_sum[gi] >= (GW+1)'(N_REQ))
                                ? GW'(cand_sum[gi] - (GW+1)'(N_REQ))
                                : cand_sum[gi][GW-1:0];
            assign req_rot[gi]  = i_req_en[cand_idx[gi]];

            assign o_req_ack[gi] = ack_fire && (grant_q == GW'(gi));
        end
    endgenerate

    // Pick the pending requester with the smallest rotation offset from rr_ptr
    always_comb begin
        pick_idx = cand_idx[0];
        for (int off = N_REQ - 1; off >= 0; off--) begin
            if (req_rot[off]) begin
                pick_idx = cand_idx[off];
            end
        end
    end

    // The requester after the one just served becomes the top priority
    assign grant_inc = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + GW'(1);

    // Next-state and datapath capture for the IDLE/ISSUE/WAIT/RESP sequencer
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        aborted_d = aborted_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        f3_d      = f3_q;
        res_d     = res_q;

        case (state_q)
            ST_IDLE: begin
                if (|i_req_en) begin
                    grant_d   = pick_idx;
                    rs1_d     = req_rs1[pick_idx];
                    rs2_d     = req_rs2[pick_idx];
                    f3_d      = req_f3[pick_idx];
                    aborted_d = 1'b0;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A unit ack during the start cycle is not legal and is ignored
                if (!i_req_en[grant_q]) begin
                    aborted_d = 1'b1;
                end
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!i_req_en[grant_q]) begin
                    aborted_d = 1'b1;
                end
                if (i_m_ack) begin
                    res_d   = i_m_res;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // Rotate even on abort, so a dropped requester loses its turn
                rr_ptr_d = grant_inc;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched operand/result registers, cleared by the async reset
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            aborted_q <= 1'b0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            f3_q      <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            aborted_q <= aborted_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            f3_q      <= f3_d;
            res_q     <= res_d;
        end
    end

    // Outputs decode from registered state only, so reset clears them at once
    assign o_m_en    = (state_q == ST_ISSUE);
    assign o_busy    = (state_q != ST_IDLE);
    assign o_m_rs1   = rs1_q;
    assign o_m_rs2   = rs2_q;
    assign o_m_f3    = f3_q;
    assign o_req_res = ack_fire ? res_q : '0;

endmodule

// File: tb/tb_rv32m_arbiter.sv
// Testbench for rv32m_arbiter: a per-cycle vector table, hand-written
// async-reset sequences, then randomized traffic checked against a
// transaction-level timing model.
module tb_rv32m_arbiter;

    localparam int XLEN = 32;
    localparam int N    = 2;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic [N-1:0]    i_req_en;
    logic [N*XLEN-1:0] i_req_rs1;
    logic [N*XLEN-1:0] i_req_rs2;
    logic [N*3-1:0]  i_req_f3;
    logic [N-1:0]    o_req_ack;
    logic [XLEN-1:0] o_req_res;
    logic            o_m_en;
    logic [XLEN-1:0] o_m_rs1;
    logic [XLEN-1:0] o_m_rs2;
    logic [2:0]      o_m_f3;
    logic            i_m_ack;
    logic [XLEN-1:0] i_m_res;
    logic            o_busy;

    rv32m_arbiter #(.XLEN(XLEN), .N_REQ(N)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req_en  (i_req_en),
        .i_req_rs1 (i_req_rs1),
        .i_req_rs2 (i_req_rs2),
        .i_req_f3  (i_req_f3),
        .o_req_ack (o_req_ack),
        .o_req_res (o_req_res),
        .o_m_en    (o_m_en),
        .o_m_rs1   (o_m_rs1),
        .o_m_rs2   (o_m_rs2),
        .o_m_f3    (o_m_f3),
        .i_m_ack   (i_m_ack),
        .i_m_res   (i_m_res),
        .o_busy    (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int tag   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step=%0d got=%h want=%h", nm, tag, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  en;
        logic        m_ack;
        logic [31:0] m_res;
        logic [1:0]  x_ack;
        logic [31:0] x_res;
        logic        x_men;
        logic        x_busy;
        logic [31:0] x_rs1;
        logic [31:0] x_rs2;
    } vec_t;

    vec_t tbl [28];

    function automatic vec_t mk(input logic [1:0] en, input logic ma, input logic [31:0] mr,
                                input logic [1:0] xa, input logic [31:0] xr, input logic xm,
                                input logic xb, input logic [31:0] x1, input logic [31:0] x2);
        vec_t v;
        v.en = en; v.m_ack = ma; v.m_res = mr; v.x_ack = xa; v.x_res = xr;
        v.x_men = xm; v.x_busy = xb; v.x_rs1 = x1; v.x_rs2 = x2;
        return v;
    endfunction

    // The shared unit as seen by the bench: any fixed function of the operands
    function automatic logic [31:0] unit_fn(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f);
        return a * b + {29'd0, f};
    endfunction

    // Transaction-level model state for the random phase
    int          free_at, issue_c, ack_c, resp_c, g, ptr, kk;
    bit          ab;
    logic [31:0] lat1, lat2, eres;
    logic [2:0]  latf;
    bit          pend [N];
    logic [31:0] q1 [N];
    logic [31:0] q2 [N];
    logic [2:0]  qf [N];
    logic [1:0]  x_ack;
    logic        x_men, x_busy;

    initial begin
        // requester 0: rs1=7 rs2=6 f3=0 ; requester 1: rs1=100 rs2=3 f3=1
        //               en     mack mres        xack xres        men busy rs1  rs2
        tbl[0]  = mk(2'b01, 0, 32'd0,      2'b00, 32'd0,      0, 0, 0,   0);
        tbl[1]  = mk(2'b01, 0, 32'd0,      2'b00, 32'd0,      1, 1, 7,   6);
        tbl[2]  = mk(2'b01, 0, 32'd0,      2'b00, 32'd0,      0, 1, 7,   6);
        tbl[3]  = mk(2'b01, 0, 32'd0,      2'b00, 32'd0,      0, 1, 7,   6);
        tbl[4]  = mk(2'b01, 0, 32'd0,      2'b00, 32'd0,      0, 1, 7,   6);
        tbl[5]  = mk(2'b01, 1, 32'd42,     2'b00, 32'd0,      0, 1, 7,   6);
        tbl[6]  = mk(2'b01, 0, 32'd0,      2'b01, 32'd42,     0, 1, 7,   6);
        tbl[7]  = mk(2'b00, 0, 32'd0,      2'b00, 32'd0,      0, 0, 7,   6);
        tbl[8]  = mk(2'b10, 1, 32'd5,      2'b00, 32'd0,      0, 0, 7,   6);
        tbl[9]  = mk(2'b10, 1, 32'd5,      2'b00, 32'd0,      1, 1, 100, 3);
        tbl[10] = mk(2'b10, 0, 32'd0,      2'b00, 32'd0,      0, 1, 100, 3);
        tbl[11] = mk(2'b10, 1, 32'h1234,   2'b00, 32'd0,      0, 1, 100, 3);
        tbl[12] = mk(2'b10, 1, 32'h77,     2'b10, 32'h1234,   0, 1, 100, 3);
        tbl[13] = mk(2'b00, 1, 32'h88,     2'b00, 32'd0,      0, 0, 100, 3);
        tbl[14] = mk(2'b11, 0, 32'd0,      2'b00, 32'd0,      0, 0, 100, 3);
        tbl[15] = mk(2'b11, 0, 32'd0,      2'b00, 32'd0,      1, 1, 7,   6);
        tbl[16] = mk(2'b11, 1, 32'd50,     2'b00, 32'd0,      0, 1, 7,   6);
        tbl[17] = mk(2'b11, 0, 32'd0,      2'b01, 32'd50,     0, 1, 7,   6);
        tbl[18] = mk(2'b10, 0, 32'd0,      2'b00, 32'd0,      0, 0, 7,   6);
        tbl[19] = mk(2'b10, 0, 32'd0,      2'b00, 32'd0,      1, 1, 100, 3);
        tbl[20] = mk(2'b01, 0, 32'd0,      2'b00, 32'd0,      0, 1, 100, 3);
        tbl[21] = mk(2'b01, 1, 32'hDEAD,   2'b00, 32'd0,      0, 1, 100, 3);
        tbl[22] = mk(2'b01, 0, 32'd0,      2'b00, 32'd0,      0, 1, 100, 3);
        tbl[23] = mk(2'b01, 0, 32'd0,      2'b00, 32'd0,      0, 0, 100, 3);
        tbl[24] = mk(2'b01, 0, 32'd0,      2'b00, 32'd0,      1, 1, 7,   6);
        tbl[25] = mk(2'b01, 1, 32'd9,      2'b00, 32'd0,      0, 1, 7,   6);
        tbl[26] = mk(2'b01, 0, 32'd0,      2'b01, 32'd9,      0, 1, 7,   6);
        tbl[27] = mk(2'b00, 0, 32'd0,      2'b00, 32'd0,      0, 0, 7,   6);

        i_rst     = 1'b0;
        i_req_en  = '0;
        i_req_rs1 = {32'd100, 32'd7};
        i_req_rs2 = {32'd3, 32'd6};
        i_req_f3  = {3'd1, 3'd0};
        i_m_ack   = 1'b0;
        i_m_res   = '0;

        // Reset state
        #2;
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_men",  32'(o_m_en), 32'd0);
        chk("rst_ack",  32'(o_req_ack), 32'd0);
        chk("rst_res",  o_req_res, 32'd0);
        chk("rst_rs1",  o_m_rs1, 32'd0);
        chk("rst_f3",   32'(o_m_f3), 32'd0);
        #10 i_rst = 1'b1;

        // ---- table-driven vectors ----
        for (int i = 0; i < 28; i++) begin
            @(posedge i_clk); #1;
            tag      = i;
            i_req_en = tbl[i].en;
            i_m_ack  = tbl[i].m_ack;
            i_m_res  = tbl[i].m_res;
            @(negedge i_clk);
            chk("tbl_ack",  32'(o_req_ack), 32'(tbl[i].x_ack));
            chk("tbl_men",  32'(o_m_en),    32'(tbl[i].x_men));
            chk("tbl_busy", 32'(o_busy),    32'(tbl[i].x_busy));
            chk("tbl_rs1",  o_m_rs1, tbl[i].x_rs1);
            chk("tbl_rs2",  o_m_rs2, tbl[i].x_rs2);
            if (tbl[i].x_ack != 2'b00) chk("tbl_res", o_req_res, tbl[i].x_res);
        end

        // ---- async reset during WAIT; rr_ptr is 1 here ----
        tag = 1000;
        @(posedge i_clk); #1 i_req_en = 2'b10; i_m_ack = 1'b0;
        @(posedge i_clk); #1;                      // ISSUE
        @(posedge i_clk); #1;                      // WAIT
        chk("pre_rst_busy", 32'(o_busy), 32'd1);
        #2 i_rst = 1'b0; i_req_en = 2'b00;
        #1;
        chk("arst_busy", 32'(o_busy), 32'd0);
        chk("arst_men",  32'(o_m_en), 32'd0);
        chk("arst_ack",  32'(o_req_ack), 32'd0);
        chk("arst_rs1",  o_m_rs1, 32'd0);
        chk("arst_rs2",  o_m_rs2, 32'd0);
        chk("arst_f3",   32'(o_m_f3), 32'd0);
        #3 i_rst = 1'b1;
        @(posedge i_clk); #1 i_m_ack = 1'b1; i_m_res = 32'hBAD;   // late unit ack
        @(posedge i_clk); #1 i_m_ack = 1'b0; i_req_en = 2'b11;
        @(negedge i_clk);
        chk("stray_busy", 32'(o_busy), 32'd0);
        chk("stray_ack",  32'(o_req_ack), 32'd0);
        @(posedge i_clk); #1;
        chk("post_rst_men", 32'(o_m_en), 32'd1);
        chk("post_rst_rs1", o_m_rs1, 32'd7);
        chk("post_rst_f3",  32'(o_m_f3), 32'd0);
        @(posedge i_clk); #1 i_m_ack = 1'b1; i_m_res = 32'd77;
        @(posedge i_clk); #1 i_m_ack = 1'b0;
        @(negedge i_clk);
        chk("post_rst_ack", 32'(o_req_ack), 32'd1);
        chk("post_rst_res", o_req_res, 32'd77);

        // ---- randomized traffic against the transaction model ----
        @(posedge i_clk); #1 i_req_en = '0; i_m_ack = 1'b0; i_rst = 1'b0;
        @(negedge i_clk); i_rst = 1'b1;
        free_at = 0; issue_c = -100; ack_c = -100; resp_c = -100;
        g = 0; ptr = 0; ab = 1'b0;
        lat1 = '0; lat2 = '0; latf = '0; eres = '0;
        for (int k = 0; k < N; k++) begin
            pend[k] = 1'b0; q1[k] = '0; q2[k] = '0; qf[k] = '0;
        end

        for (int c = 0; c < 3000; c++) begin
            @(posedge i_clk); #1;
            tag = 2000 + c;
            for (int k = 0; k < N; k++) begin
                if (!pend[k]) begin
                    if ($urandom_range(0, 1) == 0) begin
                        pend[k] = 1'b1;
                        q1[k] = $urandom;
                        q2[k] = $urandom;
                        qf[k] = 3'($urandom_range(0, 7));
                    end
                end else if ($urandom_range(0, 39) == 0) begin
                    pend[k] = 1'b0;
                end
            end
            i_req_en  = {pend[1], pend[0]};
            i_req_rs1 = {q1[1], q1[0]};
            i_req_rs2 = {q2[1], q2[0]};
            i_req_f3  = {qf[1], qf[0]};
            if (c == ack_c) begin
                i_m_ack = 1'b1; i_m_res = eres;
            end else if (!(c > issue_c && c < ack_c) && $urandom_range(0, 7) == 0) begin
                i_m_ack = 1'b1; i_m_res = $urandom;
            end else begin
                i_m_ack = 1'b0; i_m_res = $urandom;
            end

            x_busy = (c >= issue_c) && (c <= resp_c);
            x_men  = (c == issue_c);
            x_ack  = (c == resp_c && !ab) ? (2'b01 << g) : 2'b00;

            @(negedge i_clk);
            chk("rnd_ack",  32'(o_req_ack), 32'(x_ack));
            chk("rnd_men",  32'(o_m_en), 32'(x_men));
            chk("rnd_busy", 32'(o_busy), 32'(x_busy));
            chk("rnd_rs1",  o_m_rs1, lat1);
            chk("rnd_rs2",  o_m_rs2, lat2);
            chk("rnd_f3",   32'(o_m_f3), 32'(latf));
            if (x_ack != 2'b00) chk("rnd_res", o_req_res, eres);

            // advance the model with this cycle's inputs
            if (c >= issue_c && c <= ack_c && !i_req_en[g]) ab = 1'b1;
            if (c == resp_c && !ab) pend[g] = 1'b0;
            if (c >= free_at && i_req_en != '0) begin
                for (int off = N - 1; off >= 0; off--) begin
                    kk = (ptr + off) % N;
                    if (i_req_en[kk]) g = kk;
                end
                lat1    = q1[g];
                lat2    = q2[g];
                latf    = qf[g];
                eres    = unit_fn(q1[g], q2[g], qf[g]);
                issue_c = c + 1;
                ack_c   = issue_c + int'($urandom_range(1, 5));
                resp_c  = ack_c + 1;
                free_at = resp_c + 1;
                ab      = 1'b0;
                ptr     = (g + 1) % N;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
